mult_div_unit: RTL

Iterative multiply/divide unit in the execute stage, directly downstream of the register bank. It consumes the two read-port operands (dado1/dado2) and runs MULT/MULTU/DIV/DIVU over multiple cycles into private HI/LO registers. It also supports MTHI/MTLO writes and exposes HI/LO to the writeback mux. A start/busy/done handshake lets the pipeline stall while an operation is in flight.

---
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the execute-stage pipeline and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] dado1;
  logic [DATA_W-1:0] dado2;
  logic              wr_hi;
  logic              wr_lo;
  logic              flush;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;

  modport master (
    output start, op, dado1, dado2, wr_hi, wr_lo, flush,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, dado1, dado2, wr_hi, wr_lo, flush,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Optional macro MDU_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | one shift-add / shift-subtract step per edge
// FIX   | sign correction, HI/LO load
// DONE  | one-cycle done pulse, result visible on hi/lo
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  mult_div_unit_if.slave   bus
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                is_div_q;
  logic                neg_res_q;
  logic                neg_rem_q;
  logic                div0_q;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                busy_q;
  logic                done_q;

  logic                sgn_a, sgn_b;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     rem_sh, rem_diff;
  logic                q_bit;
  logic [2*DATA_W-1:0] div_next, mul_next, prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix;
  logic                calc_last;

  assign sgn_a = ~bus.op[0] & bus.dado1[DATA_W-1];
  assign sgn_b = ~bus.op[0] & bus.dado2[DATA_W-1];
  assign mag_a = sgn_a ? (DATA_W'(0) - bus.dado1) : bus.dado1;
  assign mag_b = sgn_b ? (DATA_W'(0) - bus.dado2) : bus.dado2;

  // Divide: acc holds {remainder, dividend/quotient}; a clear borrow means subtract succeeded.
  assign rem_sh   = acc[2*DATA_W-1:DATA_W-1];
  assign rem_diff = rem_sh - {1'b0, opb};
  assign q_bit    = ~rem_diff[DATA_W];
  assign div_next = q_bit ? {rem_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1}
                          : {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};

  // Multiply: multiplicand shifts left, multiplier shifts right, product accumulates in acc.
  assign mul_next = opb[0] ? (acc + mcand) : acc;

`ifdef MDU_EARLY_OUT_EN
  logic mul_last;
  assign mul_last  = (opb[DATA_W-1:1] == '0);
  assign calc_last = (cnt == '0) || (!is_div_q && mul_last);
`else
  assign calc_last = (cnt == '0);
`endif

  assign prod_fix = neg_res_q ? ((2*DATA_W)'(0) - acc) : acc;
  assign quot_fix = div0_q ? '1
                  : (neg_res_q ? (DATA_W'(0) - acc[DATA_W-1:0]) : acc[DATA_W-1:0]);
  // A zero divisor leaves |dado1| as remainder, so re-signing it restores the original dado1.
  assign rem_fix  = neg_rem_q ? (DATA_W'(0) - acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      opb       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            is_div_q  <= bus.op[1];
            neg_res_q <= sgn_a ^ sgn_b;
            neg_rem_q <= sgn_a;
            div0_q    <= bus.op[1] && (bus.dado2 == '0);
            acc       <= bus.op[1] ? {{DATA_W{1'b0}}, mag_a} : '0;
            mcand     <= {{DATA_W{1'b0}}, mag_a};
            opb       <= mag_b;
            cnt       <= CW'(DATA_W - 1);
            busy_q    <= 1'b1;
            state     <= S_CALC;
          end else begin
            if (bus.wr_hi) hi_q <= bus.dado1;
            if (bus.wr_lo) lo_q <= bus.dado1;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            if (is_div_q) begin
              acc <= div_next;
            end else begin
              acc   <= mul_next;
              mcand <= mcand << 1;
              opb   <= opb >> 1;
            end
            cnt <= cnt - 1'b1;
            if (calc_last) state <= S_FIX;
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*DATA_W-1:DATA_W];
              lo_q <= prod_fix[DATA_W-1:0];
            end
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
